// File: rtl/recovery_ctrl.sv
// recovery_ctrl: sequences branch-mispredict recovery.
//   On BPRecoverEN in IDLE the target PC is latched, then the FSM walks
//   SQUASH -> DRAIN -> REDIRECT -> IDLE.
//   SQUASH pulses the ROB/RS/FU squash and the map-table/freelist restores.
//   DRAIN drops in-flight FU completions for DRAIN_CYCLES cycles.
//   REDIRECT offers redirect_pc to fetch until fetch_ready is seen.
// Ports:
//   clock, reset                  clock and asynchronous active-high reset
//   BPRecoverEN, bp_target_pc     mispredict trigger and correct PC from retire
//   fetch_ready                   fetch accepts the redirect
//   squash, mt_restore,
//   fl_restore                    single-cycle restore strobes
//   fu_drop                       discard FU completions
//   redirect_valid, redirect_pc   redirect offered to fetch
//   dispatch_stall, retire_stall  pipeline holds while recovering
//   busy                          FSM not idle
//   recover_cnt                   completed recoveries, saturating
//   overlap_err                   sticky: trigger seen while busy
module recovery_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             BPRecoverEN,
    input  logic [XLEN-1:0]  bp_target_pc,
    input  logic             fetch_ready,
    output logic             squash,
    output logic             mt_restore,
    output logic             fl_restore,
    output logic             fu_drop,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             dispatch_stall,
    output logic             retire_stall,
    output logic             busy,
    output logic [CNT_W-1:0] recover_cnt,
    output logic             overlap_err
);

    // Counter wide enough to hold DRAIN_CYCLES (at least one bit).
    localparam int unsigned DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StSquash,
        StDrain,
        StRedirect
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] drain_q;
    logic          handshake;

    assign handshake = (state_q == StRedirect) && fetch_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (BPRecoverEN) state_d = StSquash;
            StSquash:   state_d = (DRAIN_CYCLES == 0) ? StRedirect : StDrain;
            StDrain:    if (drain_q == DW'(1)) state_d = StRedirect;
            StRedirect: if (fetch_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            drain_q        <= '0;
            redirect_pc    <= '0;
            recover_cnt    <= '0;
            overlap_err    <= 1'b0;
            squash         <= 1'b0;
            mt_restore     <= 1'b0;
            fl_restore     <= 1'b0;
            fu_drop        <= 1'b0;
            redirect_valid <= 1'b0;
            dispatch_stall <= 1'b0;
            retire_stall   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            squash         <= (state_d == StSquash);
            mt_restore     <= (state_d == StSquash);
            fl_restore     <= (state_d == StSquash);
            fu_drop        <= (state_d == StSquash) || (state_d == StDrain);
            redirect_valid <= (state_d == StRedirect);
            dispatch_stall <= (state_d != StIdle);
            retire_stall   <= (state_d != StIdle);
            busy           <= (state_d != StIdle);

            if (state_q == StIdle && BPRecoverEN) begin
                redirect_pc <= bp_target_pc;
            end

            if (state_q == StSquash) begin
                drain_q <= DW'(DRAIN_CYCLES);
            end else if (state_q == StDrain) begin
                drain_q <= drain_q - DW'(1);
            end

            if (handshake && recover_cnt != {CNT_W{1'b1}}) begin
                recover_cnt <= recover_cnt + CNT_W'(1);
            end

            // A trigger in any non-idle state, including the final REDIRECT
            // cycle, is dropped and flagged.
            if (BPRecoverEN && state_q != StIdle) begin
                overlap_err <= 1'b1;
            end
        end
    end

endmodule
